// File: rtl/reg_load_arbiter.sv
// Purpose: round-robin arbiter that loads one requester's data into a shared register.
// Latency: a grant is combinational in the grant cycle; q/q_owner update on the following edge.
// Backpressure: req_ready is withheld during reset and for HOLD_CYCLES cycles after every load.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset
//   req_valid  per-requester request (must not depend on req_ready)
//   req_data   requester i data at [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant; requester i is loaded when req_valid[i] & req_ready[i]
//   q          shared register value
//   q_owner    index of the requester that last loaded q
//   q_valid    q has been loaded at least once since reset
//   busy       high while in the post-load hold window
module reg_load_arbiter #(
   parameter int                WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   parameter int                NUM_REQ     = 4,
   parameter int                HOLD_CYCLES = 2,
   localparam int               OWNER_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         q,
   output logic [OWNER_W-1:0]       q_owner,
   output logic                     q_valid,
   output logic                     busy
);

   // The hold counter only ever holds values 0 .. HOLD_CYCLES-1.
   localparam int CNT_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam int HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t               state_q;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_nxt;
   logic [OWNER_W-1:0]   ptr_q;
   logic [OWNER_W-1:0]   ptr_nxt;

   logic                 grant_found;
   logic [OWNER_W-1:0]   grant_idx;
   logic [OWNER_W-1:0]   cand;
   logic [WIDTH-1:0]     load_dat;
   logic                 load_en;

   // Round-robin search: first valid requester starting at ptr_q, wrapping
   // modulo NUM_REQ. Earlier hits take priority, so later ones are ignored.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = OWNER_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Data of the selected requester.
   always_comb begin
      load_dat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == OWNER_W'(i)) begin
            load_dat = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer moves to the requester after the winner, wrapping at NUM_REQ-1.
   always_comb begin
      if (grant_idx == OWNER_W'(NUM_REQ - 1)) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = grant_idx + 1'b1;
      end
   end

   // FSM next-state and outputs.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      load_en   = 1'b0;
      busy      = 1'b0;
      req_ready = '0;
      case (state_q)
         ST_IDLE: begin
            // Reset suppresses the grant so nothing is loaded in a reset cycle.
            if (grant_found && !reset) begin
               req_ready[grant_idx] = 1'b1;
               load_en              = 1'b1;
               if (HOLD_CYCLES > 0) begin
                  state_nxt = ST_HOLD;
                  cnt_nxt   = CNT_W'(HOLD_INIT);
               end
            end
         end
         ST_HOLD: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt_q - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         ptr_q   <= '0;
         q       <= RESET_VALUE;
         q_owner <= '0;
         q_valid <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         if (load_en) begin
            q       <= load_dat;
            q_owner <= grant_idx;
            q_valid <= 1'b1;
            ptr_q   <= ptr_nxt;
         end
      end
   end

endmodule
